// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, direction codes, position decode and a
// popcount helper for the pending-request vector.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned POS_W      = 3;
    localparam int unsigned NUM_REQ    = 10;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Floor index (0-based) encoded in a controller position; only meaningful when even.
    function automatic logic [1:0] floor_of(input logic [POS_W-1:0] position);
        return position[2:1];
    endfunction

    function automatic logic [3:0] count_ones(input logic [NUM_REQ-1:0] vec);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            n = n + {3'b000, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/call_request_panel_if.sv
// Button interface between the request panel and the elevator controller.
// master: the panel (consumes presses/car state, drives pending requests).
// slave:  the controller/button side.
interface call_request_panel_if;
    import elevator_pkg::*;

    logic [2:0]       press_up;
    logic [2:0]       press_down;
    logic [3:0]       press_in;
    logic [POS_W-1:0] position;
    logic             open;
    logic [1:0]       direction;
    logic [2:0]       button_up;
    logic [2:0]       button_down;
    logic [3:0]       button_in;
    logic [3:0]       req_count;
    logic             stall;

    modport master (
        input  press_up, press_down, press_in, position, open, direction,
        output button_up, button_down, button_in, req_count, stall
    );

    modport slave (
        output press_up, press_down, press_in, position, open, direction,
        input  button_up, button_down, button_in, req_count, stall
    );

endinterface

// File: rtl/call_request_panel_btn_sync.sv
// btn_sync: parameterised-width two-flop synchronizer with synchronous active-low reset.
// Only present when BTN_SYNC_EN is defined, since that is the only build that uses it.
`ifdef BTN_SYNC_EN
module btn_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage shift; both stages cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule
`endif

// File: rtl/call_request_panel.sv
// call_request_panel: latches hall/car presses into pending requests, clears them when the
// car opens its door at the floor in a serving direction, and flags starvation.
// Optional feature macro BTN_SYNC_EN: presses pass through 2-flop synchronizers first.
module call_request_panel
    import elevator_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 64
) (
    input logic                  clk,
    input logic                  reset_n,
    call_request_panel_if.master bus
);

    localparam int unsigned     CntW     = $clog2(STALL_CYCLES + 1);
    localparam logic [CntW-1:0] StallMax = CntW'(STALL_CYCLES);

    logic [2:0] up_s;
    logic [2:0] down_s;
    logic [3:0] in_s;

`ifdef BTN_SYNC_EN
    btn_sync #(.Width(3)) u_sync_up (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.press_up),
        .dout    (up_s)
    );
    btn_sync #(.Width(3)) u_sync_down (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.press_down),
        .dout    (down_s)
    );
    btn_sync #(.Width(4)) u_sync_in (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.press_in),
        .dout    (in_s)
    );
`else
    assign up_s   = bus.press_up;
    assign down_s = bus.press_down;
    assign in_s   = bus.press_in;
`endif

    logic [1:0]            cur_floor;
    logic [NUM_FLOORS-1:0] serve;
    logic [2:0]            clr_up;
    logic [2:0]            clr_down;
    logic [3:0]            clr_in;
    logic [2:0]            up_q, up_d;
    logic [2:0]            down_q, down_d;
    logic [3:0]            in_q, in_d;
    logic [3:0]            count_q;
    logic                  open_q;
    logic                  open_rise;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  cnt_clr;
    logic                  stall_q, stall_d;

    // Decode the served floor and compute next pending state; clear beats a same-cycle set.
    always_comb begin
        cur_floor = floor_of(bus.position);
        serve     = '0;
        if (!bus.position[0] && bus.open) begin
            serve[cur_floor] = 1'b1;
        end
        clr_in   = serve;
        clr_up   = (bus.direction != DIR_DOWN) ? serve[2:0] : 3'b000;  // hall-up F1..F3
        clr_down = (bus.direction != DIR_UP)   ? serve[3:1] : 3'b000;  // hall-down F2..F4
        up_d     = (up_q | up_s) & ~clr_up;
        down_d   = (down_q | down_s) & ~clr_down;
        in_d     = (in_q | in_s) & ~clr_in;
    end

    // Starvation counter: restarts on an empty queue or a new door opening, else saturates.
    always_comb begin
        open_rise = bus.open & ~open_q;
        cnt_clr   = ({up_d, down_d, in_d} == '0) || open_rise;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_q == StallMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Raised once the counter has sat at the limit; dropped as soon as it restarts.
        stall_d = !cnt_clr && (cnt_q == StallMax);
    end

    // All panel state, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            up_q    <= '0;
            down_q  <= '0;
            in_q    <= '0;
            count_q <= '0;
            open_q  <= 1'b0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            up_q    <= up_d;
            down_q  <= down_d;
            in_q    <= in_d;
            count_q <= count_ones({up_d, down_d, in_d});
            open_q  <= bus.open;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.button_up   = up_q;
    assign bus.button_down = down_q;
    assign bus.button_in   = in_q;
    assign bus.req_count   = count_q;
    assign bus.stall       = stall_q;

endmodule
